delay_line_ch: RTL and testbench

- Programmable delay stage directly downstream of the channel pulse generator.
- Consumes that generator's launch_DL level, which goes high at the end of the channel pulse.
- After a programmable number of clk_Pulse cycles it raises PL_launch, which starts the next channel's pulse generator.
- PL_launch is held high until launch_DL falls, matching the level-hold semantics of the generator's PL_launch input.

---
 rtl/dl_pkg.sv | 14 +
 rtl/dl_edge_sync.sv | 46 ++++
 rtl/delay_line_ch.sv | 128 ++++++++++++
 tb/tb_delay_line_ch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared definitions for the channel delay-line stages: FSM state encoding,
// default counter width and synchronizer depth.
package dl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } dl_state_t;

    localparam int DL_WIDTH_DEF   = 36;
    localparam int DL_SYNC_STAGES = 2;

endpackage

// File: rtl/dl_edge_sync.sv
// Launch-level conditioning for a delay-line stage: optional input
// synchronizer (enabled by the DL_SYNC_EN macro) followed by a one-flop
// history register used for rising-edge detection.
module dl_edge_sync
    import dl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic lvl_in_i,
    output logic lvl_o,
    output logic rise_o
);

`ifdef DL_SYNC_EN
    logic [DL_SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous launch level through the synchronizer chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DL_SYNC_STAGES-2:0], lvl_in_i};
        end
    end

    assign lvl_o = sync_q[DL_SYNC_STAGES-1];
`else
    assign lvl_o = lvl_in_i;
`endif

    logic launch_q;

    // Remember last cycle's level so a low->high transition can be seen.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            launch_q <= 1'b0;
        end else begin
            launch_q <= lvl_o;
        end
    end

    assign rise_o = lvl_o & ~launch_q;

endmodule

// File: rtl/delay_line_ch.sv
// Programmable delay stage between two channel pulse generators. A rising
// launch_DL starts a count of 'delay' cycles, after which PL_launch is held
// high until launch_DL falls. Defining DL_SYNC_EN inserts a synchronizer
// on launch_DL, adding two cycles to every latency.
module delay_line_ch
    import dl_pkg::*;
#(
    parameter int WIDTH = DL_WIDTH_DEF
) (
    input  logic             clk_Pulse,
    input  logic             rst,
    input  logic             DL_en,
    input  logic             launch_DL,
    input  logic [WIDTH-1:0] delay,
    output logic             PL_launch,
    output logic             DL_busy,
    output logic             DL_abort
);

    logic             lvl;
    logic             rise;

    dl_state_t        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dly_lat_q, dly_lat_d;
    logic             pl_q, pl_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;
    logic             armed_q;

    dl_edge_sync u_edge (
        .clk_i    (clk_Pulse),
        .rst_i    (rst),
        .lvl_in_i (launch_DL),
        .lvl_o    (lvl),
        .rise_o   (rise)
    );

    // The first edge after reset release only re-arms the stage, so a launch
    // level that was already high across reset is not mistaken for a rise.
    always_ff @(posedge clk_Pulse or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // Next-state and output decisions; disable takes priority over launch.
    // NOTE: every signal gets its hold/default value first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dly_lat_d = dly_lat_q;
        pl_d      = pl_q;
        busy_d    = busy_q;
        abort_d   = 1'b0;

        if (!armed_q) begin
            state_d = IDLE;
        end else if (!DL_en) begin
            state_d = IDLE;
            pl_d    = 1'b0;
            busy_d  = 1'b0;
            abort_d = (state_q == COUNT);
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        dly_lat_d = delay;
                        cnt_d     = '0;
                        state_d   = COUNT;
                        busy_d    = 1'b1;
                    end
                end
                COUNT: begin
                    if (!lvl) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                        busy_d  = 1'b0;
                    end else if (cnt_q >= dly_lat_q) begin
                        pl_d    = 1'b1;
                        state_d = FIRE;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                FIRE: begin
                    if (!lvl) begin
                        pl_d    = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pl_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; reset drops outputs immediately.
    always_ff @(posedge clk_Pulse or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dly_lat_q <= '0;
            pl_q      <= 1'b0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dly_lat_q <= dly_lat_d;
            pl_q      <= pl_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;
        end
    end

    assign PL_launch = pl_q;
    assign DL_busy   = busy_q;
    assign DL_abort  = abort_q;

endmodule

// File: tb/tb_delay_line_ch.sv
// Self-checking bench for delay_line_ch: directed scenarios with literal
// timing expectations plus randomized launches checked every cycle against
// a cycle-arithmetic reference model.
module tb_delay_line_ch;

    localparam int W = 36;
`ifdef DL_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic         clk_Pulse;
    logic         rst;
    logic         DL_en;
    logic         launch_DL;
    logic [W-1:0] delay;
    logic         PL_launch;
    logic         DL_busy;
    logic         DL_abort;

    logic [W-1:0] all_ones;

    int checks   = 0;
    int failures = 0;

    delay_line_ch #(.WIDTH(W)) dut (
        .clk_Pulse (clk_Pulse),
        .rst       (rst),
        .DL_en     (DL_en),
        .launch_DL (launch_DL),
        .delay     (delay),
        .PL_launch (PL_launch),
        .DL_busy   (DL_busy),
        .DL_abort  (DL_abort)
    );

    initial clk_Pulse = 1'b0;
    always #5 clk_Pulse = ~clk_Pulse;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_Pulse);
    endtask

    // ---------------- reference model ----------------
    // A launch is "active" from the edge its rise is seen; it fires once more
    // than 'lat' edges have elapsed since then, and ends when the level drops
    // or the stage is disabled. Ending before firing is an abort.
    bit     hist[$];
    bit     m_armed, m_active, m_prev, m_pl, m_busy, m_abort;
    longint m_start, m_lat, cyc;

    initial cyc = 0;

    always @(posedge clk_Pulse or posedge rst) begin
        if (rst) begin
            m_armed  = 0;
            m_active = 0;
            m_prev   = 0;
            m_pl     = 0;
            m_busy   = 0;
            m_abort  = 0;
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        end else begin
            bit lvl;
            bit rise;
            cyc++;
            hist.push_back(launch_DL);
            lvl  = hist.pop_front();
            rise = lvl && !m_prev;
            m_abort = 0;
            if (!m_armed) begin
                m_armed = 1;
            end else if (!DL_en) begin
                m_abort  = m_active && !m_pl;
                m_active = 0;
                m_pl     = 0;
            end else if (!m_active) begin
                if (rise) begin
                    m_active = 1;
                    m_start  = cyc;
                    m_lat    = longint'(delay);
                end
            end else if (!lvl) begin
                m_abort  = !m_pl;
                m_active = 0;
                m_pl     = 0;
            end else if (cyc - m_start > m_lat) begin
                m_pl = 1;
            end
            m_busy = m_active;
            m_prev = lvl;
        end
    end

    // Compare every cycle, shortly after the active edge.
    always @(posedge clk_Pulse) begin
        #2;
        if (!rst) begin
            check("model_PL_launch", PL_launch, m_pl);
            check("model_DL_busy", DL_busy, m_busy);
            check("model_DL_abort", DL_abort, m_abort);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        int hold;
        int r;
        all_ones  = '1;
        rst       = 1'b1;
        DL_en     = 1'b1;
        launch_DL = 1'b0;
        delay     = '0;
        step(3);
        check("reset_PL_launch", PL_launch, 1'b0);
        check("reset_DL_busy", DL_busy, 1'b0);
        check("reset_DL_abort", DL_abort, 1'b0);
        rst = 1'b0;
        step(3);

        // delay=0: fire one edge after the rise is seen
        delay = W'(0);
        launch_DL = 1'b1;
        step(1 + SYNC);
        check("d0_busy_at_E0", DL_busy, 1'b1);
        check("d0_pl_low_at_E0", PL_launch, 1'b0);
        step(1);
        check("d0_pl_high_E0p1", PL_launch, 1'b1);
        step(8);
        launch_DL = 1'b0;
        step(SYNC);
        check("d0_pl_held", PL_launch, 1'b1);
        step(1);
        check("d0_pl_fall", PL_launch, 1'b0);
        check("d0_busy_fall", DL_busy, 1'b0);
        step(3);

        // delay=7 with a mid-count change of delay that must be ignored
        delay = W'(7);
        launch_DL = 1'b1;
        step(3);
        delay = W'(2);
        step(5 + SYNC);
        check("d7_pl_low_E0p7", PL_launch, 1'b0);
        step(1);
        check("d7_pl_high_E0p8", PL_launch, 1'b1);
        step(11);
        launch_DL = 1'b0;
        step(SYNC);
        check("d7_pl_held", PL_launch, 1'b1);
        step(1);
        check("d7_pl_fall", PL_launch, 1'b0);
        step(3);

        // abort: level drops before the count completes
        delay = W'(10);
        launch_DL = 1'b1;
        step(4);
        launch_DL = 1'b0;
        step(1 + SYNC);
        check("abort_pulse", DL_abort, 1'b1);
        check("abort_busy", DL_busy, 1'b0);
        check("abort_pl", PL_launch, 1'b0);
        step(1);
        check("abort_one_cycle", DL_abort, 1'b0);
        step(3);

        // enable dropped during COUNT; re-enable needs a fresh rise
        delay = W'(10);
        launch_DL = 1'b1;
        step(3 + SYNC);
        check("en_busy_count", DL_busy, 1'b1);
        DL_en = 1'b0;
        step(1);
        check("en_abort", DL_abort, 1'b1);
        check("en_busy_drop", DL_busy, 1'b0);
        DL_en = 1'b1;
        step(15);
        check("en_no_refire_pl", PL_launch, 1'b0);
        check("en_no_refire_busy", DL_busy, 1'b0);
        launch_DL = 1'b0;
        step(2 + SYNC);
        delay = W'(1);
        launch_DL = 1'b1;
        step(1 + SYNC);
        check("en_new_rise_busy", DL_busy, 1'b1);
        step(1);
        check("en_new_rise_pl_low", PL_launch, 1'b0);
        step(1);
        check("en_new_rise_pl_high", PL_launch, 1'b1);
        launch_DL = 1'b0;
        step(1 + SYNC);
        check("en_new_rise_fall", PL_launch, 1'b0);
        step(3);

        // back-to-back launches separated by a single low cycle
        delay = W'(3);
        for (int i = 0; i < 3; i++) begin
            launch_DL = 1'b1;
            step(4 + SYNC);
            check("b2b_pl_low", PL_launch, 1'b0);
            step(1);
            check("b2b_pl_high", PL_launch, 1'b1);
            launch_DL = 1'b0;
            step(1);
        end
        step(4);

        // maximum delay never fires within the run; dropping aborts
        delay = all_ones;
        launch_DL = 1'b1;
        step(30);
        check("max_busy", DL_busy, 1'b1);
        check("max_no_fire", PL_launch, 1'b0);
        launch_DL = 1'b0;
        step(1 + SYNC);
        check("max_abort", DL_abort, 1'b1);
        step(3);

        // asynchronous reset while firing
        delay = W'(5);
        launch_DL = 1'b1;
        step(7 + SYNC);
        check("rst_pre_fire", PL_launch, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_pl", PL_launch, 1'b0);
        check("rst_async_busy", DL_busy, 1'b0);
        check("rst_async_abort", DL_abort, 1'b0);
        step(2);
        rst = 1'b0;
        step(12);
`ifndef DL_SYNC_EN
        check("rst_no_refire_pl", PL_launch, 1'b0);
        check("rst_no_refire_busy", DL_busy, 1'b0);
`endif
        launch_DL = 1'b0;
        step(4);

        // randomized launches against the model
        for (int ep = 0; ep < 250; ep++) begin
            gap  = $urandom_range(1, 6);
            hold = $urandom_range(1, 30);
            r    = $urandom_range(0, 9);
            launch_DL = 1'b0;
            step(gap);
            if (r == 0)      delay = all_ones;
            else if (r == 1) delay = W'($urandom_range(0, 40));
            else             delay = W'($urandom_range(0, 6));
            launch_DL = 1'b1;
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 39) == 0) DL_en = ~DL_en;
                else if (!DL_en && $urandom_range(0, 3) == 0) DL_en = 1'b1;
                if ($urandom_range(0, 7) == 0) delay = W'($urandom);
                step(1);
            end
            DL_en = 1'b1;
        end

        launch_DL = 1'b0;
        step(6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
